// File: rtl/alarm_pkg.sv
// Shared constants, FSM encoding and the round-robin arbitration helper
// for the alarm scheduler.
package alarm_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ON   = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  localparam int DEF_N_CH       = 3;
  localparam int DEF_DEBOUNCE   = 8;
  localparam int DEF_ON_CYCLES  = 31;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int MAX_CH         = 8;

  // Rotate the request vector so the channel after 'last' sits at bit 0,
  // priority-encode the lowest set bit, then rotate the index back.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input int n_ch, input int last);
    logic [MAX_CH-1:0] rot;
    int idx;
    int first;
    rot   = '0;
    first = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n_ch) begin
        idx = last + 1 + k;
        if (idx >= n_ch) idx -= n_ch;
        rot[k] = req[idx[2:0]];
      end
    end
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    idx = last + 1 + first;
    if (idx >= n_ch) idx -= n_ch;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Sensor-side inputs and buzzer-side outputs of the alarm scheduler.
interface alarm_scheduler_if #(
  parameter int N_CH = 3
) ();
  logic            ena;
  logic [N_CH-1:0] sensor;
  logic            clear;
  logic [N_CH-1:0] buzzer_sel;
  logic            buzzer_active;
  logic [N_CH-1:0] pending;
  logic            busy;

  modport master (output ena, sensor, clear,
                  input  buzzer_sel, buzzer_active, pending, busy);
  modport slave  (input  ena, sensor, clear,
                  output buzzer_sel, buzzer_active, pending, busy);
endinterface

// File: rtl/sensor_debounce.sv
// Single-channel debouncer: one event pulse per run of DEBOUNCE high samples;
// a low sample is needed to re-arm.
module sensor_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sensor,
  output logic event_pulse
);
  localparam int CW = $clog2(DEBOUNCE);

  logic [CW-1:0] cnt;
  logic          armed;
  logic          terminal;

  assign terminal    = (cnt == CW'(DEBOUNCE - 1));
  assign event_pulse = ena && sensor && armed && terminal;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (ena) begin
      if (!sensor) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (armed) begin
        if (terminal) begin
          cnt   <= '0;
          armed <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/alarm_scheduler.sv
// Round-robin buzzer arbiter: latches debounced sensor events as pending
// requests and serves them with a fixed ON window followed by a silent gap.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  alarm_scheduler_if.slave  bus
);
  localparam int TMR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int IW      = $clog2(N_CH);

  logic [1:0]      state;
  logic [TW-1:0]   tmr;
  logic [N_CH-1:0] buzzer_sel;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] events;
  logic [N_CH-1:0] grant_oh;
  logic [N_CH-1:0] grant_clr;
  logic [IW-1:0]   rr_last;
  logic [IW-1:0]   pick;
  logic [2:0]      pick_full;

  for (genvar g = 0; g < N_CH; g++) begin : g_db
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (bus.ena),
      .sensor      (bus.sensor[g]),
      .event_pulse (events[g])
    );
  end

  assign pick_full = rr_pick(MAX_CH'(pending), N_CH, int'(rr_last));
  assign pick      = pick_full[IW-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_oh  = N_CH'(1) << pick;
    grant_clr = '0;
    if (state == ST_IDLE && |pending) grant_clr = grant_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      buzzer_sel <= '0;
      pending    <= '0;
      rr_last    <= IW'(N_CH - 1);
    end else if (bus.ena) begin
      if (bus.clear) begin
        state      <= ST_IDLE;
        tmr        <= '0;
        buzzer_sel <= '0;
        pending    <= '0;
      end else begin
        // A fresh event on the channel being granted survives the grant clear.
        pending <= (pending & ~grant_clr) | events;
        case (state)
          ST_IDLE: begin
            if (|pending) begin
              state      <= ST_ON;
              buzzer_sel <= grant_oh;
              rr_last    <= pick;
              tmr        <= '0;
            end
          end
          ST_ON: begin
            if (tmr == TW'(ON_CYCLES - 1)) begin
              buzzer_sel <= '0;
              tmr        <= '0;
              state      <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          ST_GAP: begin
            if (tmr == TW'(GAP_CYCLES - 1)) begin
              state <= ST_IDLE;
              tmr   <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.buzzer_sel    = buzzer_sel;
  assign bus.buzzer_active = |buzzer_sel;
  assign bus.pending       = pending;
  assign bus.busy          = (state == ST_ON) || (state == ST_GAP);
endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: directed scenarios plus random
// traffic, compared against a run-length / countdown reference model.
module tb_alarm_scheduler;
  localparam int N_CH       = 3;
  localparam int DEBOUNCE   = 8;
  localparam int ON_CYCLES  = 31;
  localparam int GAP_CYCLES = 4;
  localparam int OW         = 2 * N_CH + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  alarm_scheduler_if #(.N_CH(N_CH)) bus ();

  alarm_scheduler #(
    .N_CH(N_CH), .DEBOUNCE(DEBOUNCE), .ON_CYCLES(ON_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: consecutive-high run length per channel, a pending set,
  // and countdowns for the remaining ON and GAP cycles.
  int              run [N_CH];
  logic [N_CH-1:0] m_pend;
  int              m_cur, on_left, gap_left, m_last;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) run[i] = 0;
    m_pend = '0; m_cur = -1; on_left = 0; gap_left = 0; m_last = N_CH - 1;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] ev;
    int c;
    bit found;
    if (!rst_n) begin model_reset(); return; end
    if (!bus.ena) return;
    ev = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sensor[i]) begin
        if (run[i] <= DEBOUNCE) run[i]++;
        if (run[i] == DEBOUNCE) ev[i] = 1'b1;
      end else run[i] = 0;
    end
    if (bus.clear) begin
      m_pend = '0; m_cur = -1; on_left = 0; gap_left = 0;
      return;
    end
    if (on_left > 0) begin
      on_left--;
      if (on_left == 0) begin m_cur = -1; gap_left = GAP_CYCLES; end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (m_pend != 0) begin
      found = 0;
      for (int k = 1; k <= N_CH; k++) begin
        c = (m_last + k) % N_CH;
        if (!found && m_pend[c]) begin found = 1; m_cur = c; end
      end
      m_pend[m_cur] = 1'b0; m_last = m_cur; on_left = ON_CYCLES;
    end
    m_pend |= ev;
  endtask

  function automatic logic [OW-1:0] expected();
    logic [N_CH-1:0] s;
    s = (m_cur >= 0) ? N_CH'(1) << m_cur : '0;
    return {s, m_pend, (on_left > 0 || gap_left > 0), |s};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {bus.buzzer_sel, bus.pending, bus.busy, bus.buzzer_active};
  endfunction

  function automatic int sel_index(input logic [N_CH-1:0] s);
    int r = -1;
    for (int i = 0; i < N_CH; i++) if (s[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.sensor = '0; bus.clear = 1'b0; bus.ena = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL reset_state got=%b want=%b", observed(), {OW{1'b0}});
    end
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("FAIL reset_model got=%b want=%b", observed(), expected());
    end
  endtask

  task automatic test_single_event();
    int rise = -1, fall = -1, idle = -1;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      bus.sensor = (t < DEBOUNCE) ? N_CH'(1) : '0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL single cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (rise < 0 && bus.buzzer_sel != 0) rise = cyc;
      if (rise >= 0 && fall < 0 && bus.buzzer_sel == 0) fall = cyc;
      if (fall >= 0 && idle < 0 && !bus.busy) idle = cyc;
    end
    checks++;
    if (rise != 9 || fall != 40 || idle != 44) begin
      errors++; $display("FAIL single_timing got rise=%0d fall=%0d idle=%0d want 9 40 44", rise, fall, idle);
    end
  endtask

  task automatic test_glitch();
    int grants = 0;
    logic [N_CH-1:0] seen = '0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      bus.sensor = (t < DEBOUNCE - 1) ? N_CH'(2) : '0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      seen |= bus.pending;
      if (bus.buzzer_sel != 0) grants++;
    end
    checks++;
    if (grants != 0 || seen != 0) begin
      errors++; $display("FAIL glitch_none got grants=%0d pend=%b want 0 000", grants, seen);
    end
  endtask

  task automatic test_contention();
    int r0 = -1, r2 = -1;
    do_reset();
    for (int t = 0; t < 90; t++) begin
      bus.sensor = (t < DEBOUNCE) ? N_CH'(5) : '0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL contention cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (r0 < 0 && bus.buzzer_sel == 3'b001) r0 = cyc;
      if (r2 < 0 && bus.buzzer_sel == 3'b100) r2 = cyc;
    end
    checks++;
    if (r0 != 9 || r2 != 45) begin
      errors++; $display("FAIL contention_timing got ch0=%0d ch2=%0d want 9 45", r0, r2);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [N_CH-1:0] prev = '0;
    do_reset();
    for (int t = 0; t < 240; t++) begin
      bus.sensor = ((t % (DEBOUNCE + 1)) < DEBOUNCE) ? '1 : '0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL round_robin cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (prev == 0 && bus.buzzer_sel != 0) order.push_back(sel_index(bus.buzzer_sel));
      prev = bus.buzzer_sel;
    end
    checks++;
    if (order.size() < 6) begin
      errors++; $display("FAIL rr_count got=%0d want>=6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (order[k] != k % N_CH) begin
          errors++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, order[k], k % N_CH);
        end
      end
    end
  endtask

  task automatic test_held_sensor();
    int grants = 0;
    logic [N_CH-1:0] prev = '0;
    do_reset();
    for (int t = 0; t < 220; t++) begin
      bus.sensor = (t < 200) ? N_CH'(1) : '0;
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL held cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (prev == 0 && bus.buzzer_sel != 0) grants++;
      prev = bus.buzzer_sel;
    end
    checks++;
    if (grants != 1) begin
      errors++; $display("FAIL held_once got=%0d want=1", grants);
    end
  endtask

  task automatic test_reset_mid_on();
    int grants = 0;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      bus.sensor = (t < DEBOUNCE) ? N_CH'(1) : '0;
      tick();
    end
    checks++;
    if (bus.buzzer_sel !== 3'b001) begin
      errors++; $display("FAIL mid_on_pre got=%b want=001", bus.buzzer_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL async_reset got=%b want=%b", observed(), {OW{1'b0}});
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.sensor = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (bus.buzzer_sel != 0) grants++;
    end
    checks++;
    if (grants != 0) begin
      errors++; $display("FAIL post_reset_grant got=%0d want=0", grants);
    end
  endtask

  task automatic test_ena_stall();
    int fall = -1;
    do_reset();
    for (int t = 0; t < 70; t++) begin
      bus.sensor = (t < DEBOUNCE) ? N_CH'(1) : '0;
      bus.ena    = !(t >= 15 && t < 25);
      bus.clear  = (t == 18);
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL ena cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (cyc > 9 && fall < 0 && bus.buzzer_sel == 0) fall = cyc;
    end
    bus.ena = 1'b1; bus.clear = 1'b0;
    checks++;
    if (fall != 50) begin
      errors++; $display("FAIL ena_extend got fall=%0d want=50", fall);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int t = 0; t < 40; t++) begin
      bus.sensor = {1'b0, (t >= 5 && t < 13), (t < DEBOUNCE)};
      bus.clear  = (t == 20);
      if (t == 20) begin
        checks++;
        if (bus.pending !== 3'b010 || bus.buzzer_sel !== 3'b001) begin
          errors++; $display("FAIL clear_pre got pend=%b sel=%b want 010 001", bus.pending, bus.buzzer_sel);
        end
      end
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL clear cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
      if (t == 20) begin
        checks++;
        if (bus.pending !== 3'b000 || bus.buzzer_sel !== 3'b000 || bus.busy !== 1'b0) begin
          errors++; $display("FAIL clear_post got pend=%b sel=%b busy=%b want 000 000 0",
                             bus.pending, bus.buzzer_sel, bus.busy);
        end
      end
    end
    bus.clear = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 9) == 0) bus.sensor[i] = ~bus.sensor[i];
      bus.ena   = ($urandom_range(0, 15) != 0);
      bus.clear = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, observed(), expected());
      end
    end
    bus.ena = 1'b1; bus.clear = 1'b0; bus.sensor = '0;
  endtask

  initial begin
    bus.ena = 1'b1; bus.sensor = '0; bus.clear = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_glitch();
    test_contention();
    test_round_robin();
    test_held_sensor();
    test_reset_mid_on();
    test_ena_stall();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
